// File: rtl/ld_st_pkg.sv
// Shared types and constants for the load/store register command path.
// Holds the sequencer state encoding and active-low strobe polarities.
// No logic; imported by the sequencer and its shifter.
package ld_st_pkg;

  localparam int DEF_WIDTH = 4;

  // Active-low strobe levels for the downstream register's set/clr pins.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    CLEAR,
    PRESET
  } state_t;

endpackage

// File: rtl/ld_st_loader_nibble_shifter.sv
// Serial-in shift register with bit counter; MSB arrives first.
// Latency: word/full are combinational from the current bit; state updates at the edge.
// No backpressure: the caller gates shiftEn; flush discards a partial word.
import ld_st_pkg::*;

module nibble_shifter #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shiftEn,
  input  logic             flush,
  input  logic             serIn,
  output logic [WIDTH-1:0] word,
  output logic             full
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bitCnt;

  // Word as it will look once the current bit is shifted in.
  assign word = {shreg[WIDTH-2:0], serIn};
  // This accept completes a word.
  assign full = shiftEn && (bitCnt == CW'(WIDTH - 1));

  // Shift and count accepted bits; counter restarts after a full word.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      shreg  <= '0;
      bitCnt <= '0;
    end else if (shiftEn) begin
      shreg  <= word;
      bitCnt <= full ? '0 : bitCnt + CW'(1);
    end
  end

endmodule

// File: rtl/ld_st_loader.sv
// Sequencer assembling serial bits into a word and strobing LD_ST / set / clr.
// Latency: LD_ST one cycle after the last bit; set/clr one cycle after the request.
// ser_valid is ignored while busy (LOAD, CLEAR, PRESET); clr_req always wins.
import ld_st_pkg::*;

module ld_st_loader #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             clr_req,
  input  logic             set_req,
  output logic [WIDTH-1:0] slData,
  output logic             LD_ST,
  output logic             set,
  output logic             clr,
  output logic             busy,
  output logic [CNT_W-1:0] load_cnt
);

  state_t           state;
  logic             acceptOk;
  logic             shiftEn;
  logic             flush;
  logic             full;
  logic [WIDTH-1:0] word;

  // Only IDLE and SHIFT take bits or presets; single-cycle states ignore them.
  assign acceptOk = (state == IDLE) || (state == SHIFT);
  assign shiftEn  = acceptOk && ser_valid && !clr_req && !set_req;
  assign flush    = clr_req || (set_req && acceptOk);

  nibble_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .shiftEn (shiftEn),
    .flush   (flush),
    .serIn   (ser_in),
    .word    (word),
    .full    (full)
  );

  // Next-state and registered strobes, prioritised clear > preset > serial accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      slData   <= '0;
      LD_ST    <= 1'b0;
      set      <= STROBE_OFF;
      clr      <= STROBE_OFF;
      busy     <= 1'b0;
      load_cnt <= '0;
    end else begin
      LD_ST <= 1'b0;
      set   <= STROBE_OFF;
      clr   <= STROBE_OFF;
      busy  <= 1'b0;
      if (clr_req) begin
        state <= CLEAR;
        clr   <= STROBE_ON;
        busy  <= 1'b1;
      end else if (set_req && acceptOk) begin
        state <= PRESET;
        set   <= STROBE_ON;
        busy  <= 1'b1;
      end else if (shiftEn) begin
        if (full) begin
          state    <= LOAD;
          slData   <= word;
          LD_ST    <= 1'b1;
          busy     <= 1'b1;
          load_cnt <= load_cnt + CNT_W'(1);
        end else begin
          state <= SHIFT;
        end
      end else if (!acceptOk) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ld_st_loader.sv
// Randomised + directed bench for ld_st_loader with a word-level reference model.
// Expected outputs are queued at each edge and compared by a negedge monitor.
// Includes a behavioural downstream 4-bit register driven by the DUT outputs.
module tb_ld_st_loader;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, serIn, serValid, clrReq, setReq;
  logic [W-1:0]  slData;
  logic          ldSt, setN, clrN, busy;
  logic [CW-1:0] loadCnt;

  int checks   = 0;
  int failures = 0;

  ld_st_loader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (serIn),
    .ser_valid (serValid),
    .clr_req   (clrReq),
    .set_req   (setReq),
    .slData    (slData),
    .LD_ST     (ldSt),
    .set       (setN),
    .clr       (clrN),
    .busy      (busy),
    .load_cnt  (loadCnt)
  );

  always #5 clk = ~clk;

  // Downstream register fed by the DUT.
  logic [W-1:0] regQ = '0;
  always @(posedge clk) begin
    if (clrN === 1'b0)      regQ <= '0;
    else if (setN === 1'b0) regQ <= '1;
    else if (ldSt === 1'b1) regQ <= slData;
  end

  typedef struct {
    logic [W-1:0]  sl;
    logic          ld, st, cl, bz;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rg;
  } exp_t;

  exp_t sbQ[$];

  // Reference model: a queue of collected bits and the kind of output shown this cycle.
  int            mBits[$];
  int            mKind = 0;   // 0 none, 1 load, 2 clear, 3 preset
  logic [W-1:0]  mSl   = '0;
  int            mCnt  = 0;
  logic [W-1:0]  mReg  = '0;

  always @(posedge clk) begin
    exp_t e;
    bit   wasBusy;
    int   v;
    // Register captures what was shown during the cycle ending now.
    if (mKind == 2)      mReg = '0;
    else if (mKind == 3) mReg = '1;
    else if (mKind == 1) mReg = mSl;
    wasBusy = (mKind != 0);
    if (rst) begin
      mBits.delete(); mSl = '0; mCnt = 0; mKind = 0;
    end else if (clrReq) begin
      mBits.delete(); mKind = 2;
    end else if (setReq && !wasBusy) begin
      mBits.delete(); mKind = 3;
    end else if (serValid && !wasBusy) begin
      mBits.push_back(int'(serIn));
      mKind = 0;
      if (mBits.size() == W) begin
        v = 0;
        foreach (mBits[i]) v = v * 2 + mBits[i];
        mSl  = W'(v);
        mCnt = (mCnt + 1) % (1 << CW);
        mBits.delete();
        mKind = 1;
      end
    end else begin
      mKind = 0;
    end
    e.sl  = mSl;
    e.ld  = (mKind == 1);
    e.st  = (mKind != 3);
    e.cl  = (mKind != 2);
    e.bz  = (mKind != 0);
    e.cnt = CW'(mCnt);
    e.rg  = mReg;
    sbQ.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop the expectation for this cycle and compare every output.
  always @(negedge clk) begin
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      chk("slData",   32'(slData),  32'(e.sl));
      chk("LD_ST",    32'(ldSt),    32'(e.ld));
      chk("set",      32'(setN),    32'(e.st));
      chk("clr",      32'(clrN),    32'(e.cl));
      chk("busy",     32'(busy),    32'(e.bz));
      chk("load_cnt", 32'(loadCnt), 32'(e.cnt));
      chk("reg",      32'(regQ),    32'(e.rg));
      chk("strobe_overlap", 32'(!setN && !clrN), 32'(0));
      chk("ld_with_strobe", 32'(ldSt && (!setN || !clrN)), 32'(0));
    end
  end

  task automatic cycle(input logic v, input logic b, input logic c, input logic s, input logic r);
    serValid = v; serIn = b; clrReq = c; setReq = s; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) cycle(1'b1, w[i], 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] w;
    int r;
    rst = 1'b1; serIn = 1'b0; serValid = 1'b0; clrReq = 1'b0; setReq = 1'b0;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("rst_set", 32'(setN), 32'(1));
    chk("rst_clr", 32'(clrN), 32'(1));
    chk("rst_cnt", 32'(loadCnt), 32'(0));

    // First word 1011 back-to-back: LD_ST in the fifth cycle only.
    sendWord(4'b1011);
    chk("w1_ld", 32'(ldSt), 32'(1));
    chk("w1_sl", 32'(slData), 32'(4'b1011));
    chk("w1_cnt", 32'(loadCnt), 32'(1));
    cycle(0, 0, 0, 0, 0);
    chk("w1_ld_off", 32'(ldSt), 32'(0));
    chk("w1_reg", 32'(regQ), 32'(4'b1011));

    // Partial word with gaps, then clear.
    cycle(1, 1, 0, 0, 0); cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0); cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("c1_clr", 32'(clrN), 32'(0));
    cycle(0, 0, 0, 0, 0);
    chk("c1_clr_off", 32'(clrN), 32'(1));
    sendWord(4'b0001);
    chk("w2_sl", 32'(slData), 32'(4'b0001));
    cycle(0, 0, 0, 0, 0);
    chk("w2_reg", 32'(regQ), 32'(4'b0001));

    // Clear and preset together: clear wins.
    cycle(0, 0, 1, 1, 0);
    chk("cs_clr", 32'(clrN), 32'(0));
    chk("cs_set", 32'(setN), 32'(1));
    cycle(0, 0, 0, 0, 0);
    chk("cs_reg", 32'(regQ), 32'(0));

    // Preset during LOAD is dropped; in IDLE it strobes.
    sendWord(4'b1100);
    cycle(0, 0, 0, 1, 0);
    chk("sl_set_drop", 32'(setN), 32'(1));
    chk("w3_reg", 32'(regQ), 32'(4'b1100));
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk("si_set", 32'(setN), 32'(0));
    cycle(0, 0, 0, 0, 0);
    chk("si_set_off", 32'(setN), 32'(1));
    chk("si_reg", 32'(regQ), 32'(4'b1111));

    // 256 words with ser_valid held high, including the LOAD cycles.
    for (int k = 0; k < 256; k++)
      for (int b = 0; b < W + 1; b++) cycle(1, 1'($urandom), 0, 0, 0);
    chk("wrap_cnt", 32'(loadCnt), 32'(3));

    // Reset mid-word, then a clean word.
    cycle(1, 1, 0, 0, 0); cycle(1, 1, 0, 0, 0); cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("mr_sl", 32'(slData), 32'(0));
    chk("mr_cnt", 32'(loadCnt), 32'(0));
    chk("mr_busy", 32'(busy), 32'(0));
    sendWord(4'b0110);
    chk("w4_sl", 32'(slData), 32'(4'b0110));
    chk("w4_cnt", 32'(loadCnt), 32'(1));

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), r >= 1 && r < 5, r >= 5 && r < 10, r < 1);
    end

    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sbQ.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
